// File: rtl/comparator_seq_nbit_pkg.sv
// Shared constants for the sequential chunked magnitude comparator: FSM state codes,
// one-hot result encodings {g,l,eq}, and the index-counter width helper.
package cmp_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [2:0] RES_G  = 3'b100;
  localparam logic [2:0] RES_L  = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b001;

  // A single-chunk configuration still needs a 1-bit counter to stay legal.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/comparator_seq_nbit_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice; used once by the
// sequential comparator to examine the current most-significant chunk.
module comparator_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         lt,
  output logic         eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/comparator_seq_nbit.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per clock MSB-first with early exit.
// Optional build macro SIGNED_CMP_EN selects two's-complement operands.
module comparator_seq_nbit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             g_out,
  output logic             l_out,
  output logic             eq_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(NCHUNK);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] a_cmp;
  logic [WIDTH-1:0] b_cmp;
  logic [IDX_W-1:0] idx;
  logic [2:0]       result;
  logic             accept;
  logic             chunk_gt;
  logic             chunk_lt;
  logic             chunk_eq;

`ifdef SIGNED_CMP_EN
  // Flipping the sign bit maps two's complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
  assign a_cmp = a_in ^ SIGN_MASK;
  assign b_cmp = b_in ^ SIGN_MASK;
`else
  assign a_cmp = a_in;
  assign b_cmp = b_in;
`endif

  assign accept = start_in && ((state == ST_IDLE) || (state == ST_DONE));

  // Operand registers shift left each step, so the live chunk is always the top one.
  comparator_chunk #(.W(CHUNK)) u_chunk (
    .a  (a_reg[WIDTH-1 -: CHUNK]),
    .b  (b_reg[WIDTH-1 -: CHUNK]),
    .gt (chunk_gt),
    .lt (chunk_lt),
    .eq (chunk_eq)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= ST_IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      idx    <= '0;
      result <= '0;
    end else if (accept) begin
      state  <= ST_COMPARE;
      a_reg  <= a_cmp;
      b_reg  <= b_cmp;
      idx    <= IDX_W'(NCHUNK - 1);
      result <= '0;
    end else begin
      case (state)
        ST_COMPARE: begin
          if (chunk_gt) begin
            result <= RES_G;
            state  <= ST_DONE;
          end else if (chunk_lt) begin
            result <= RES_L;
            state  <= ST_DONE;
          end else if (chunk_eq && (idx == '0)) begin
            result <= RES_EQ;
            state  <= ST_DONE;
          end else begin
            idx   <= idx - IDX_W'(1);
            a_reg <= a_reg << CHUNK;
            b_reg <= b_reg << CHUNK;
          end
        end
        ST_IDLE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_out = (state == ST_COMPARE);
  assign done_out = (state == ST_DONE);
  assign {g_out, l_out, eq_out} = result;

endmodule
